// File: rtl/scanner_scheduler_pkg.sv
// Shared encodings for the two-scanner ping-pong scheduler: scanner states,
// scheduler states and the A/B link select values.
package scanner_pkg;

  typedef enum logic [2:0] {
    SC_OFF          = 3'b000,
    SC_STANDBY      = 3'b001,
    SC_SCANNING     = 3'b010,
    SC_IDLE         = 3'b011,
    SC_TRANSFERRING = 3'b100,
    SC_FLUSHING     = 3'b101
  } scan_state_t;

  typedef enum logic [2:0] {
    S_OFF   = 3'b000,
    S_BOOT  = 3'b001,
    S_RUN   = 3'b010,
    S_DRAIN = 3'b011
  } sched_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/scanner_scheduler_if.sv
// Control bundle between the user/scanner side and the scheduler.
interface scanner_scheduler_if;
  logic       start, stop;
  logic [2:0] a_state, b_state;
  logic       a_ready, b_ready;
  logic       a_other_standby, a_other_scan, a_other_flush;
  logic       b_other_standby, b_other_scan, b_other_flush;
  logic       a_initial_on, a_go_standby, a_start_scan, a_start_transfer, a_flush;
  logic       b_initial_on, b_go_standby, b_start_scan, b_start_transfer, b_flush;
  logic       xfer_sel, xfer_busy;
  logic [2:0] sched_state;
  logic       wd_error;

  modport slave (
    input  start, stop, a_state, b_state, a_ready, b_ready,
           a_other_standby, a_other_scan, a_other_flush,
           b_other_standby, b_other_scan, b_other_flush,
    output a_initial_on, a_go_standby, a_start_scan, a_start_transfer, a_flush,
           b_initial_on, b_go_standby, b_start_scan, b_start_transfer, b_flush,
           xfer_sel, xfer_busy, sched_state, wd_error
  );

  modport master (
    output start, stop, a_state, b_state, a_ready, b_ready,
           a_other_standby, a_other_scan, a_other_flush,
           b_other_standby, b_other_scan, b_other_flush,
    input  a_initial_on, a_go_standby, a_start_scan, a_start_transfer, a_flush,
           b_initial_on, b_go_standby, b_start_scan, b_start_transfer, b_flush,
           xfer_sel, xfer_busy, sched_state, wd_error
  );
endinterface

// File: rtl/scanner_scheduler_xfer_arbiter.sv
// Shared transfer-link arbiter: ready edge detect, round-robin grant, release,
// flush deferral, and a transfer watchdog when SCHED_WATCHDOG_EN is defined.
module xfer_arbiter
  import scanner_pkg::*;
`ifdef SCHED_WATCHDOG_EN
#(
  parameter int WD_LIMIT = 64
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic       a_ready,
  input  logic       b_ready,
  input  logic [2:0] a_state,
  input  logic [2:0] b_state,
  input  logic       flush_req_a,
  input  logic       flush_req_b,
  output logic       a_start_transfer,
  output logic       b_start_transfer,
  output logic       a_flush,
  output logic       b_flush,
  output logic       xfer_sel,
  output logic       xfer_busy,
  output logic       wd_error,
  output logic       idle
);
  logic ready_q_a, ready_q_b, pend_a, pend_b, held_a, held_b, ptr, seen;
  logic req_a, req_b, grant_any, grant_a, grant_b;
  logic cur_xfer, release_n, release_any, wd_trip;
  logic busy_a, busy_b, wd_a, wd_b;
  logic flush_a_d, flush_b_d, held_a_d, held_b_d;

  assign req_a     = pend_a | (a_ready & ~ready_q_a);
  assign req_b     = pend_b | (b_ready & ~ready_q_b);
  assign grant_any = ~xfer_busy & (req_a | req_b);
  assign grant_b   = grant_any & req_b & (~req_a | (ptr == SEL_B));
  assign grant_a   = grant_any & ~grant_b;

  // Release only after the owner has actually been seen TRANSFERRING.
  assign cur_xfer    = ((xfer_sel == SEL_B) ? b_state : a_state) == SC_TRANSFERRING;
  assign release_n   = xfer_busy & seen & ~cur_xfer;
  assign release_any = release_n | wd_trip;

  assign busy_a = xfer_busy & (xfer_sel == SEL_A);
  assign busy_b = xfer_busy & (xfer_sel == SEL_B);
  assign wd_a   = wd_trip & (xfer_sel == SEL_A);
  assign wd_b   = wd_trip & (xfer_sel == SEL_B);

  assign flush_a_d = (flush_req_a & ~busy_a) | (held_a & ~xfer_busy) | wd_a;
  assign flush_b_d = (flush_req_b & ~busy_b) | (held_b & ~xfer_busy) | wd_b;
  assign held_a_d  = wd_a ? 1'b0 : (flush_req_a & busy_a) ? 1'b1 :
                     (held_a & ~xfer_busy) ? 1'b0 : held_a;
  assign held_b_d  = wd_b ? 1'b0 : (flush_req_b & busy_b) ? 1'b1 :
                     (held_b & ~xfer_busy) ? 1'b0 : held_b;

  assign idle = ~xfer_busy & ~req_a & ~req_b & ~held_a & ~held_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q_a        <= 1'b0;
      ready_q_b        <= 1'b0;
      pend_a           <= 1'b0;
      pend_b           <= 1'b0;
      held_a           <= 1'b0;
      held_b           <= 1'b0;
      ptr              <= SEL_A;
      seen             <= 1'b0;
      a_start_transfer <= 1'b0;
      b_start_transfer <= 1'b0;
      a_flush          <= 1'b0;
      b_flush          <= 1'b0;
      xfer_sel         <= SEL_A;
      xfer_busy        <= 1'b0;
    end else begin
      ready_q_a        <= a_ready;
      ready_q_b        <= b_ready;
      pend_a           <= req_a & ~grant_a;
      pend_b           <= req_b & ~grant_b;
      a_start_transfer <= grant_a;
      b_start_transfer <= grant_b;
      a_flush          <= flush_a_d;
      b_flush          <= flush_b_d;
      held_a           <= held_a_d;
      held_b           <= held_b_d;
      if (grant_any) begin
        xfer_sel <= grant_b ? SEL_B : SEL_A;
        ptr      <= grant_b ? SEL_A : SEL_B;
      end
      if (release_any)    xfer_busy <= 1'b0;
      else if (grant_any) xfer_busy <= 1'b1;
      if (grant_any || release_any)   seen <= 1'b0;
      else if (xfer_busy && cur_xfer) seen <= 1'b1;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WD_LIMIT + 1);
  logic [WW-1:0] wd_cnt;

  assign wd_trip = xfer_busy & ~release_n & (wd_cnt == WW'(WD_LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt   <= '0;
      wd_error <= 1'b0;
    end else begin
      wd_cnt   <= xfer_busy ? wd_cnt + WW'(1) : '0;
      wd_error <= wd_error | wd_trip;
    end
  end
`else
  assign wd_trip  = 1'b0;
  assign wd_error = 1'b0;
`endif

endmodule

// File: rtl/scanner_scheduler.sv
// Top-level sequencer for the two-scanner ping-pong system: boot, relay, drain,
// and link arbitration. Optional transfer watchdog: SCHED_WATCHDOG_EN.
module scanner_scheduler
  import scanner_pkg::*;
#(
  parameter int BOOT_WAIT = 8,
  parameter int WD_LIMIT  = 64
) (
  input  logic clk,
  input  logic reset,
  scanner_scheduler_if.slave bus
);
  localparam int BW = $clog2(BOOT_WAIT + 1);

  sched_state_t  state, state_d;
  logic [BW-1:0] boot_cnt, boot_cnt_d;
  logic a_init_d, b_init_d, a_stby_d, b_stby_d, a_scan_d, b_scan_d;
  logic a_init_q, b_init_q, a_stby_q, b_stby_q, a_scan_q, b_scan_q;
  logic relay_en, scan_en, both_standby, link_idle, wd_flag;
  logic flush_req_a, flush_req_b;

  assign relay_en     = (state == S_RUN) || (state == S_DRAIN);
  assign scan_en      = (state == S_RUN);
  assign both_standby = (bus.a_state == SC_STANDBY) && (bus.b_state == SC_STANDBY);
  assign flush_req_a  = relay_en & bus.b_other_flush;
  assign flush_req_b  = relay_en & bus.a_other_flush;

  always_comb begin
    state_d    = state;
    boot_cnt_d = boot_cnt;
    a_init_d   = 1'b0;
    b_init_d   = 1'b0;
    a_stby_d   = relay_en & bus.b_other_standby;
    b_stby_d   = relay_en & bus.a_other_standby;
    a_scan_d   = scan_en & bus.b_other_scan;
    b_scan_d   = scan_en & bus.a_other_scan;
    unique case (state)
      S_OFF: if (bus.start) begin
        state_d    = S_BOOT;
        boot_cnt_d = '0;
        a_init_d   = 1'b1;
        b_init_d   = 1'b1;
      end
      S_BOOT: begin
        if (bus.stop) begin
          state_d = S_OFF;
        end else if (both_standby || boot_cnt == BW'(BOOT_WAIT - 1)) begin
          state_d  = S_RUN;
          a_scan_d = 1'b1;
        end else begin
          boot_cnt_d = boot_cnt + BW'(1);
        end
      end
      S_RUN: if (bus.stop) state_d = S_DRAIN;
      S_DRAIN: if (link_idle) begin
        state_d  = S_OFF;
        a_stby_d = 1'b1;
        b_stby_d = 1'b1;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_OFF;
      boot_cnt <= '0;
      a_init_q <= 1'b0;
      b_init_q <= 1'b0;
      a_stby_q <= 1'b0;
      b_stby_q <= 1'b0;
      a_scan_q <= 1'b0;
      b_scan_q <= 1'b0;
    end else begin
      state    <= state_d;
      boot_cnt <= boot_cnt_d;
      a_init_q <= a_init_d;
      b_init_q <= b_init_d;
      a_stby_q <= a_stby_d;
      b_stby_q <= b_stby_d;
      a_scan_q <= a_scan_d;
      b_scan_q <= b_scan_d;
    end
  end

  assign bus.a_initial_on = a_init_q;
  assign bus.b_initial_on = b_init_q;
  assign bus.a_go_standby = a_stby_q;
  assign bus.b_go_standby = b_stby_q;
  assign bus.a_start_scan = a_scan_q;
  assign bus.b_start_scan = b_scan_q;
  assign bus.sched_state  = state;
  // A non-positive limit leaves the watchdog flag permanently clear.
  assign bus.wd_error     = wd_flag & (WD_LIMIT > 0);

  xfer_arbiter
`ifdef SCHED_WATCHDOG_EN
    #(.WD_LIMIT(WD_LIMIT))
`endif
  u_arb (
    .clk              (clk),
    .reset            (reset),
    .a_ready          (bus.a_ready),
    .b_ready          (bus.b_ready),
    .a_state          (bus.a_state),
    .b_state          (bus.b_state),
    .flush_req_a      (flush_req_a),
    .flush_req_b      (flush_req_b),
    .a_start_transfer (bus.a_start_transfer),
    .b_start_transfer (bus.b_start_transfer),
    .a_flush          (bus.a_flush),
    .b_flush          (bus.b_flush),
    .xfer_sel         (bus.xfer_sel),
    .xfer_busy        (bus.xfer_busy),
    .wd_error         (wd_flag),
    .idle             (link_idle)
  );

endmodule

// File: tb/tb_scanner_scheduler.sv
// Directed bench for scanner_scheduler; the watchdog scenario follows SCHED_WATCHDOG_EN.
module tb_scanner_scheduler;
  import scanner_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   busy_cycles;

  scanner_scheduler_if bus();

  scanner_scheduler #(.BOOT_WAIT(8), .WD_LIMIT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset               = 1'b0;
    bus.start           = 1'b0;
    bus.stop            = 1'b0;
    bus.a_state         = SC_OFF;
    bus.b_state         = SC_OFF;
    bus.a_ready         = 1'b0;
    bus.b_ready         = 1'b0;
    bus.a_other_standby = 1'b0;
    bus.a_other_scan    = 1'b0;
    bus.a_other_flush   = 1'b0;
    bus.b_other_standby = 1'b0;
    bus.b_other_scan    = 1'b0;
    bus.b_other_flush   = 1'b0;
    #2;
    chk("rst_state", bus.sched_state, 32'd0);
    chk("rst_cmds", {bus.a_initial_on, bus.a_go_standby, bus.a_start_scan, bus.a_start_transfer,
                     bus.a_flush, bus.b_initial_on, bus.b_go_standby, bus.b_start_scan,
                     bus.b_start_transfer, bus.b_flush, bus.xfer_sel, bus.xfer_busy,
                     bus.wd_error}, 32'd0);
    tick; tick;
    reset = 1'b1;
    tick;

    // Boot with both scanners reaching STANDBY
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("boot_init_on", {bus.a_initial_on, bus.b_initial_on}, 32'd3);
    chk("boot_state", bus.sched_state, 32'd1);
    tick;
    chk("boot_init_pulse", {bus.a_initial_on, bus.b_initial_on}, 32'd0);
    tick;
    bus.a_state = SC_STANDBY;
    bus.b_state = SC_STANDBY;
    tick;
    chk("boot_start_scan", {bus.a_start_scan, bus.b_start_scan}, 32'd2);
    chk("boot_run", bus.sched_state, 32'd2);
    tick;
    chk("boot_scan_pulse", bus.a_start_scan, 32'd0);

    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("start_ignored", {bus.sched_state, bus.a_initial_on}, {28'd0, 3'd2, 1'b0});

    // Relays
    bus.a_other_standby = 1'b1;
    tick;
    bus.a_other_standby = 1'b0;
    chk("relay_standby", {bus.a_go_standby, bus.b_go_standby}, 32'd1);
    tick;
    chk("relay_standby_pulse", bus.b_go_standby, 32'd0);
    tick;
    bus.a_other_scan = 1'b1;
    tick;
    bus.a_other_scan = 1'b0;
    chk("relay_scan", {bus.a_start_scan, bus.b_start_scan}, 32'd1);
    bus.b_other_flush = 1'b1;
    tick;
    bus.b_other_flush = 1'b0;
    chk("relay_flush_free", {bus.a_flush, bus.b_flush}, 32'd2);
    tick;

    // Collision: both ready edges together, pointer at A
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    tick;
    chk("coll_grant_a", {bus.a_start_transfer, bus.b_start_transfer, bus.xfer_sel, bus.xfer_busy},
        32'b1001);
    bus.a_state = SC_TRANSFERRING;
    tick;
    chk("coll_hold", {bus.a_start_transfer, bus.b_start_transfer, bus.xfer_busy}, 32'b001);
    tick;
    bus.a_state = SC_IDLE;
    tick;
    chk("coll_release", {bus.xfer_busy, bus.xfer_sel, bus.b_start_transfer}, 32'b000);
    tick;
    chk("coll_grant_b", {bus.a_start_transfer, bus.b_start_transfer, bus.xfer_sel, bus.xfer_busy},
        32'b0111);
    bus.b_state = SC_TRANSFERRING;
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    tick; tick;
    bus.b_state = SC_IDLE;
    tick;
    chk("b_release_sel_hold", {bus.xfer_busy, bus.xfer_sel}, 32'b01);
    tick;

    // Deferred flush to the link owner, with stop during the transfer
    bus.a_ready = 1'b1;
    tick;
    chk("defer_grant_a", {bus.a_start_transfer, bus.xfer_sel, bus.xfer_busy}, 32'b101);
    bus.a_state = SC_TRANSFERRING;
    tick;
    bus.b_other_flush = 1'b1;
    tick;
    bus.b_other_flush = 1'b0;
    chk("defer_held", bus.a_flush, 32'd0);
    bus.stop = 1'b1;
    tick;
    bus.stop = 1'b0;
    chk("drain_enter", {bus.sched_state, bus.a_go_standby, bus.b_go_standby},
        {27'd0, 3'd3, 2'b00});
    tick;
    chk("drain_wait", {bus.sched_state, bus.xfer_busy}, {28'd0, 3'd3, 1'b1});
    bus.a_state = SC_IDLE;
    tick;
    chk("defer_release", {bus.xfer_busy, bus.a_flush}, 32'b00);
    tick;
    chk("defer_flush", {bus.a_flush, bus.a_go_standby, bus.b_go_standby}, 32'b100);
    tick;
    chk("drain_standby", {bus.a_go_standby, bus.b_go_standby, bus.sched_state},
        {27'd0, 2'b11, 3'd0});
    bus.a_ready = 1'b0;
    tick;
    chk("drain_standby_pulse", {bus.a_go_standby, bus.b_go_standby}, 32'd0);

    bus.stop = 1'b1;
    tick;
    bus.stop = 1'b0;
    chk("stop_ignored_off", bus.sched_state, 32'd0);

    // Boot timeout with scanners stuck at OFF
    bus.a_state = SC_OFF;
    bus.b_state = SC_OFF;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("tmo_boot", bus.sched_state, 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick;
      chk("tmo_wait", {bus.a_start_scan, bus.sched_state}, {28'd0, 1'b0, 3'd1});
    end
    tick;
    chk("tmo_start_scan", {bus.a_start_scan, bus.sched_state}, {28'd0, 1'b1, 3'd2});

    // Long transfer: watchdog trips at 64 busy cycles only when built in
    bus.a_ready = 1'b1;
    tick;
    chk("wd_grant", {bus.a_start_transfer, bus.xfer_busy}, 32'b11);
    bus.a_ready = 1'b0;
    bus.a_state = SC_TRANSFERRING;
    busy_cycles = 0;
    while (bus.xfer_busy && busy_cycles < 100) begin
      busy_cycles++;
      tick;
    end
`ifdef SCHED_WATCHDOG_EN
    chk("wd_busy_cycles", busy_cycles, 32'd64);
    chk("wd_trip", {bus.a_flush, bus.xfer_busy, bus.wd_error}, 32'b101);
    bus.a_state = SC_IDLE;
    tick; tick;
    chk("wd_sticky", {bus.wd_error, bus.xfer_busy, bus.a_flush}, 32'b100);
`else
    chk("nowd_busy_cycles", busy_cycles, 32'd100);
    chk("nowd_flag", {bus.wd_error, bus.xfer_busy, bus.a_flush}, 32'b010);
    bus.a_state = SC_IDLE;
    tick;
    chk("nowd_release", bus.xfer_busy, 32'd0);
`endif

    // Asynchronous reset mid-cycle
    reset = 1'b0;
    #1;
    chk("async_rst", {bus.sched_state, bus.wd_error, bus.xfer_busy}, 32'd0);
    tick;
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scanner_scheduler.md
Name: scanner_scheduler

Overview:
- Top-level sequencer for the two-scanner ping-pong system.
- Powers both scanners up and starts scanner A.
- Relays each scanner's cross-scanner handoff pulses (other-standby, other-scan, other-flush) to its partner.
- Arbitrates the single shared transfer link, which both scanners reach via readyToTransfer.
- Sits between the user controls and the two scanner instances, and drives the data-out mux select.

Parameters:
BOOT_WAIT, 8, maximum cycles to wait in boot for both scanners to reach STANDBY before proceeding anyway.
WD_LIMIT, 64, watchdog cycle limit for one granted transfer (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  user start pulse
stop  in  1  user stop pulse
a_state  in  3  scanner A state
b_state  in  3  scanner B state
a_ready  in  1  scanner A readyToTransfer
b_ready  in  1  scanner B readyToTransfer
a_other_standby, a_other_scan, a_other_flush  in  1 each  A's requests aimed at B
b_other_standby, b_other_scan, b_other_flush  in  1 each  B's requests aimed at A
a_initial_on, a_go_standby, a_start_scan, a_start_transfer, a_flush  out  1 each  commands to A
b_initial_on, b_go_standby, b_start_scan, b_start_transfer, b_flush  out  1 each  commands to B
xfer_sel  out  1  data-out mux select (0 = A, 1 = B)
xfer_busy  out  1  transfer link owned
sched_state  out  3  current scheduler state
wd_error  out  1  watchdog error flag (tied 0 without the optional feature)

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0, sched_state = S_OFF, pending flags cleared, round-robin pointer = A, deferred flushes dropped.
- Command outputs:
  - All are registered one-cycle pulses.
  - Each is asserted exactly one cycle after the triggering input is sampled.
- Scanner state encoding: OFF=000, STANDBY=001, SCANNING=010, IDLE=011, TRANSFERRING=100, FLUSHING=101.
- Scheduler FSM:
  - S_OFF (000): start -> S_BOOT, pulsing a_initial_on and b_initial_on.
  - S_BOOT (001): when both states == STANDBY, or after BOOT_WAIT cycles, pulse a_start_scan -> S_RUN. stop -> S_OFF.
  - S_RUN (010):
    - x_other_standby -> pulse partner go_standby.
    - x_other_scan -> pulse partner start_scan.
    - x_other_flush -> pulse partner flush.
    - stop -> S_DRAIN.
  - S_DRAIN (011):
    - other_scan relays are suppressed; standby and flush relays continue.
    - Once no request is pending and xfer_busy = 0, pulse go_standby to both -> S_OFF.
- start outside S_OFF is ignored. stop in S_OFF is ignored.
- Transfer arbitration:
  - A rising edge of x_ready sets pending_x. The level of x_ready is ignored.
  - When the link is free and a request is pending, pulse x_start_transfer, set xfer_sel, set xfer_busy = 1, and clear pending_x.
  - Grant occurs one cycle after the request edge if the link is free.
  - If both requests are pending in the same cycle, grant the round-robin pointer's scanner. The pointer flips to the other scanner after every grant.
  - Link release:
    - xfer_busy clears on the first cycle the granted scanner's state != TRANSFERRING, after it has been TRANSFERRING for at least one cycle.
    - xfer_sel holds its last value after release.
    - A new grant may occur on the cycle after release.
- Flush deferral:
  - A relayed flush aimed at the scanner currently granted the link is held pending.
  - The held flush is issued the cycle after that scanner's release.
  - Further flushes arriving for the same scanner while one is held merge into the single held flush.
- Simultaneous relays to the same target in one cycle are all issued in the same cycle (distinct output pins).

Optional Feature:
- Macro: SCHED_WATCHDOG_EN.
- With the macro defined:
  - A counter runs while xfer_busy = 1.
  - When it reaches WD_LIMIT, the scheduler pulses flush to the granted scanner, force-releases the link, and sets sticky wd_error (cleared only by reset).
  - The round-robin pointer behaves as after a normal grant.
- Without the macro: no counter is built and wd_error is tied to 0.

Decomposition:
- Package scanner_pkg holds the scanner state encodings, the scheduler state encodings (S_OFF..S_DRAIN), and the A/B select constants.
- One natural sub-module: xfer_arbiter, which contains the edge detectors, pending flags, round-robin pointer, grant/release logic, flush deferral and the watchdog.

Test Plan:
- Boot: reset release, start pulse, both states -> STANDBY at cycle 3 -> initial_on pulses at cycle 1; a_start_scan one cycle after STANDBY is seen; sched_state = 010.
- Boot timeout: start with states held at OFF -> a_start_scan exactly BOOT_WAIT cycles after entering S_BOOT.
- Relay: a_other_standby pulsed, then a_other_scan three cycles later -> b_go_standby and b_start_scan each follow one cycle later.
- Collision: a_ready and b_ready rise together with pointer = A -> a_start_transfer and xfer_sel = 0. After A leaves TRANSFERRING -> b_start_transfer the cycle after release, xfer_sel = 1.
- Deferred flush and drain:
  - b_other_flush while A holds the link -> a_flush appears the cycle after A's release.
  - stop during that transfer -> go_standby to both only after release; sched_state returns to 000.
- Watchdog (SCHED_WATCHDOG_EN, WD_LIMIT = 64): grant A, hold a_state = TRANSFERRING -> a_flush and xfer_busy = 0 at busy cycle 64; wd_error = 1 until reset.
